// File: rtl/tandem_app_axil_led_if.sv
// AXI4-Lite bus bundle for the tandem LED register bank.
interface tandem_app_axil_led_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/tandem_app_axil_led.sv
// AXI4-Lite register bank driving an LED array (off / on / blink / PWM).
// Map: 0x00 ID, 0x04 SCRATCH, 0x08 CTRL, 0x0C PRESCALE, 0x10+4n LED_CFG[n].
// Optional macro LED_PWM_EN: adds the PWM counter, duty field and mode 3
// drive. Without it, mode 3 is stored but the LED stays dark and duty reads 0.
module tandem_app_axil_led #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDR_WIDTH   = 16,
   parameter int          STRB_WIDTH   = 4,
   parameter int          LED_COUNT    = 8,
   parameter logic [31:0] ID_VALUE     = 32'h1ED0_0001,
   parameter logic [31:0] PRESCALE_RST = 32'd25_000_000
) (
   input  logic                 axi_aclk,
   input  logic                 axi_areset,
   tandem_app_axil_led_if.slave s_axil,
   output logic [LED_COUNT-1:0] LED
);

   localparam int IW = ADDR_WIDTH - 2;

   logic                  ready_en;
   logic                  aw_held;
   logic [IW-1:0]         aw_idx;
   logic                  w_held;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  rvalid_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [31:0] scratch;
   logic [31:0] prescale;
   logic [31:0] pre_cnt;
   logic        ctrl_en;
   logic        blink_ph;
   logic [1:0]  cfg_mode [LED_COUNT];
`ifdef LED_PWM_EN
   logic [7:0]  cfg_duty [LED_COUNT];
   logic [7:0]  pwm_cnt;
`endif

   logic          commit;
   logic          wr_err;
   logic          clr_cnt;
   logic [IW-1:0] ar_idx;
   logic [31:0]   rd_data;
   logic          rd_err;

   // ready_en keeps every ready low while reset is applied and for the first edge after it
   assign s_axil.awready = ready_en && !aw_held && !bvalid_q;
   assign s_axil.wready  = ready_en && !w_held && !bvalid_q;
   assign s_axil.arready = ready_en && !rvalid_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rdata   = rdata_q;

   assign commit  = aw_held && w_held && !bvalid_q;
   assign wr_err  = aw_idx >= IW'(4 + LED_COUNT);
   assign clr_cnt = commit && (aw_idx == IW'(2)) && w_strb[0] && w_data[1];
   assign ar_idx  = s_axil.araddr[ADDR_WIDTH-1:2];

   // Capture AW and W independently, commit once both are held, then respond on B
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         ready_en <= 1'b0;
         aw_held  <= 1'b0;
         aw_idx   <= '0;
         w_held   <= 1'b0;
         w_data   <= '0;
         w_strb   <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= 2'b00;
      end else begin
         ready_en <= 1'b1;
         if (s_axil.awvalid && s_axil.awready) begin
            aw_held <= 1'b1;
            aw_idx  <= s_axil.awaddr[ADDR_WIDTH-1:2];
         end
         if (s_axil.wvalid && s_axil.wready) begin
            w_held <= 1'b1;
            w_data <= s_axil.wdata;
            w_strb <= s_axil.wstrb;
         end
         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err ? 2'b10 : 2'b00;
         end else if (bvalid_q && s_axil.bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // Register file update on commit, byte-wise under wstrb
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         scratch  <= '0;
         prescale <= PRESCALE_RST;
         ctrl_en  <= 1'b0;
         for (int n = 0; n < LED_COUNT; n++) begin
            cfg_mode[n] <= 2'b00;
`ifdef LED_PWM_EN
            cfg_duty[n] <= 8'h00;
`endif
         end
      end else if (commit) begin
         if (aw_idx == IW'(1)) begin
            for (int b = 0; b < 4; b++)
               if (w_strb[b]) scratch[8*b +: 8] <= w_data[8*b +: 8];
         end else if (aw_idx == IW'(2)) begin
            if (w_strb[0]) ctrl_en <= w_data[0];
         end else if (aw_idx == IW'(3)) begin
            for (int b = 0; b < 4; b++)
               if (w_strb[b]) prescale[8*b +: 8] <= w_data[8*b +: 8];
         end else begin
            for (int n = 0; n < LED_COUNT; n++) begin
               if (aw_idx == IW'(n + 4)) begin
                  if (w_strb[0]) cfg_mode[n] <= w_data[1:0];
`ifdef LED_PWM_EN
                  if (w_strb[1]) cfg_duty[n] <= w_data[15:8];
`endif
               end
            end
         end
      end
   end

   // Blink prescaler and PWM counter; a counter clear beats the increment
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         pre_cnt  <= '0;
         blink_ph <= 1'b0;
`ifdef LED_PWM_EN
         pwm_cnt  <= 8'h00;
`endif
      end else if (clr_cnt) begin
         pre_cnt  <= '0;
         blink_ph <= 1'b0;
`ifdef LED_PWM_EN
         pwm_cnt  <= 8'h00;
`endif
      end else if (ctrl_en) begin
         // >= so that lowering PRESCALE below the running count wraps immediately
         if (pre_cnt >= prescale) begin
            pre_cnt  <= '0;
            blink_ph <= ~blink_ph;
         end else begin
            pre_cnt <= pre_cnt + 32'd1;
         end
`ifdef LED_PWM_EN
         pwm_cnt <= pwm_cnt + 8'd1;
`endif
      end
   end

   // Read mux over the decoded word index
   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (ar_idx >= IW'(4 + LED_COUNT)) begin
         rd_err = 1'b1;
      end else if (ar_idx == IW'(0)) begin
         rd_data = ID_VALUE;
      end else if (ar_idx == IW'(1)) begin
         rd_data = scratch;
      end else if (ar_idx == IW'(2)) begin
         rd_data = {31'b0, ctrl_en};
      end else if (ar_idx == IW'(3)) begin
         rd_data = prescale;
      end else begin
         for (int n = 0; n < LED_COUNT; n++) begin
            if (ar_idx == IW'(n + 4)) begin
               rd_data[1:0] = cfg_mode[n];
`ifdef LED_PWM_EN
               rd_data[15:8] = cfg_duty[n];
`endif
            end
         end
      end
   end

   // Register read response on AR handshake and hold it until rready
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         rvalid_q <= 1'b0;
         rresp_q  <= 2'b00;
         rdata_q  <= '0;
      end else if (s_axil.arvalid && s_axil.arready) begin
         rvalid_q <= 1'b1;
         rresp_q  <= rd_err ? 2'b10 : 2'b00;
         rdata_q  <= rd_data;
      end else if (rvalid_q && s_axil.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   // Registered LED drive from mode, blink phase and PWM compare
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         LED <= '0;
      end else begin
         for (int n = 0; n < LED_COUNT; n++) begin
            if (!ctrl_en) begin
               LED[n] <= 1'b0;
            end else begin
               case (cfg_mode[n])
                  2'd0: LED[n] <= 1'b0;
                  2'd1: LED[n] <= 1'b1;
                  2'd2: LED[n] <= blink_ph;
`ifdef LED_PWM_EN
                  2'd3: LED[n] <= (pwm_cnt < cfg_duty[n]);
`else
                  2'd3: LED[n] <= 1'b0;
`endif
               endcase
            end
         end
      end
   end

endmodule

// File: doc/tandem_app_axil_led.md
Name: tandem_app_axil_led

Overview:
AXI4-Lite slave register bank that drives a parametrised LED array, used by the tandem application in place of the fixed-zero LED tie-off.
- Per-channel LED mode: off, on, blink or PWM.
- Global enable, a blink prescaler, a scratch register and a read-only ID register.
- Sits on the same AXI-Lite segment as the debug bridge, behind the host interconnect.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- ADDR_WIDTH, 16, AXI-Lite address width.
- STRB_WIDTH, 4, write strobe width; equals DATA_WIDTH/8.
- LED_COUNT, 8, number of LED channels, 1..32.
- ID_VALUE, 32'h1ED0_0001, value returned by the ID register.
- PRESCALE_RST, 32'd25_000_000, reset value of PRESCALE.

Ports:
- axi_aclk  in  1  sole clock.
- axi_areset  in  1  reset; asynchronous, active-high.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid/awready  in/out  1  AW handshake.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid/wready  in/out  1  W handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid/bready  out/in  1  B handshake.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid/arready  in/out  1  AR handshake.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid/rready  out/in  1  R handshake.
- LED  out  LED_COUNT  registered LED drive, 1 = lit.

Behaviour:
- Reset values (async): all *ready 0, all *valid 0, bresp/rresp 0, rdata 0, LED 0, SCRATCH 0, CTRL 0, PRESCALE = PRESCALE_RST, all LED_CFG 0, all counters 0, blink phase 0.
- Address decode: addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- Register map (byte offsets):
  - 0x00 ID (RO). Writes are accepted with OKAY and have no effect.
  - 0x04 SCRATCH (RW).
  - 0x08 CTRL (RW): bit0 = global enable. bit1 = counter clear; write 1 clears it, reads as 0.
  - 0x0C PRESCALE (RW): blink half-period in clocks, minus 1.
  - 0x10+4n LED_CFG[n], n < LED_COUNT (RW): [1:0] mode (0 off, 1 on, 2 blink, 3 pwm), [15:8] duty. Other bits read 0.
  - Any other address: SLVERR (2'b10). Reads return 0; writes are discarded.
- Write path:
  - AW and W are captured independently into one-entry holding registers, in either order.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - When both are held and bvalid = 0, the commit happens that cycle: byte-wise per wstrb, holds cleared. bvalid rises the next cycle.
  - bvalid/bresp are held until bready. No new AW or W is accepted while bvalid = 1.
  - Same-cycle AW+W with empty holds: captured, commit next cycle, bvalid the cycle after. Latency 2 cycles from handshake.
- Read path:
  - arready = !rvalid.
  - The AR handshake registers rdata/rresp and asserts rvalid the next cycle. These are held stable until rready.
  - Back-to-back reads: one per 2 cycles with rready tied high.
  - Read and write may proceed concurrently. A read issued in the commit cycle returns the pre-commit value.
- Prescaler:
  - 32-bit counter increments each clock while CTRL.bit0 = 1.
  - On reaching PRESCALE it emits a one-cycle tick, wraps to 0 and toggles blink phase.
  - PRESCALE = 0 → tick every clock.
  - A write of PRESCALE below the current count wraps at the next compare: counter is reset to 0 when count >= PRESCALE.
- PWM counter: 8-bit free-running, wraps 255→0, counts only while enabled.
- Counter clear (CTRL.bit1 write 1): zeroes the prescaler, PWM counter and blink phase in the commit cycle; takes priority over increment.
- LED[n], registered (1 cycle after config change):
  - CTRL.bit0 = 0 → 0.
  - Mode 0 → 0; mode 1 → 1; mode 2 → blink phase.
  - Mode 3 → (pwm_cnt < duty). duty 0 is always off; duty 255 is off 1 of 256 cycles.
- Reset mid-transaction: all handshake state is dropped immediately. The master must re-issue.

Optional Feature:
Macro LED_PWM_EN.
- Defined: PWM counter, duty field and mode 3 are present as above.
- Undefined: no PWM counter. Duty bits are not stored and read 0. Mode 3 stores and reads back as 3 but drives LED 0.

Test Plan:
- Reset: assert axi_areset mid-write → all valid/ready 0, LED 0; reads after release return ID=0x1ED00001, SCRATCH=0, PRESCALE=0x017D7840.
- W issued 3 cycles before AW to 0x04, data 0xA5A5_5A5A, wstrb 4'b0101 → bvalid 2 cycles after the AW handshake, bresp 0; SCRATCH reads 0x00A5_005A.
- Write 0x0C=3, CTRL=1, LED_CFG[0]=2 → LED[0] toggles every 4 clocks; write CTRL=3 → phase and counters cleared, LED[0]=0 the next cycle.
- LED_CFG[1]=0x0000_4003 with enable and LED_PWM_EN defined → LED[1] high for exactly 64 of every 256 cycles; with the macro undefined → LED[1] stays 0 and the readback is 0x3.
- Read 0x1000 and write 0x1000 → rresp/bresp = 2'b10, rdata 0, no register changed.
- Hold bready/rready low for 10 cycles → bvalid/rvalid and their data stay stable, awready/wready/arready stay 0.
